status_cond_unit: RTL
=====================

# status_cond_unit

Holds the architectural NZCV status register of the ARM pipeline and evaluates instruction condition codes against it. Flag writes come from the EXE-stage ALU (N, Z, C, V plus the executing command). The condition check serves the instruction in ID and bypasses same-cycle flag writes, so back-to-back flag-setting and conditional instructions need no stall. A saturating counter records how many ID instructions were annulled by a failed condition, for performance inspection.

## Interface
- CNT_W, 16, width of the annulled-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- exe_valid  in  1  EXE holds a real instruction (0 for bubble)
- exe_s  in  1  S bit of the EXE instruction (update flags)
- exe_cmd  in  4  EXE_CMD of the EXE instruction
- alu_n, alu_z, alu_c, alu_v  in  1 each  flags from the ALU this cycle
- id_valid  in  1  ID holds a real instruction
- id_cond  in  4  condition field [31:28] of the ID instruction
- freeze  in  1  hazard stall of IF/ID this cycle
- flush  in  1  branch taken; the ID instruction is being squashed
- cnt_clr  in  1  synchronous clear of the annul counter
- sr  out  4  registered NZCV, bit order {N,Z,C,V}
- carry_in  out  1  sr[1], drives the ALU C input
- cond_pass  out  1  ID instruction's condition holds (combinational)
- annul_cnt  out  CNT_W  saturating count of annulled instructions

## Operation
- Flag write occurs when exe_valid && exe_s.
- Arithmetic commands 0010, 0011, 0100 and 0101 write all of N, Z, C and V.
- Logical and move commands 0001, 1001, 0110, 0111 and 1000 write N and Z only; C and V keep their values.
- Any other exe_cmd writes nothing. This covers NOP and branch (0000) and undefined codes.
- Next-flags value: sr_next equals sr with the selected bits replaced by the alu_* values.
- Condition evaluation uses eff = sr_next. This is the bypass: the check sees the flags the EXE instruction is writing this cycle.
- Condition decode on eff:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: 0
- cond_pass equals the decode result ANDed with id_valid.
- Counter increment condition: id_valid && !cond_pass && !freeze && !flush. Each ID instruction is counted once, on the cycle it leaves ID.
- Counter saturates at all-ones and does not wrap.
- cnt_clr has priority over increment. With both active the counter becomes 0.

## Timing
- Reset: sr = 4'b0000, carry_in = 0, annul_cnt = 0. cond_pass reflects id_cond against zero flags; with id_valid=0 it is 0.
- Reset is asynchronous and may assert mid-operation. Its effect is immediate; a pending flag write is lost.
- sr updates on the rising edge after the EXE cycle. Latency to sr is 1 cycle; latency to cond_pass is 0 cycles (bypass).
- freeze and flush do not block the flag write. EXE receives a bubble in those cases, and the bubble arrives with exe_valid=0.
- cond_pass is combinational from the exe_* and id_* inputs and sr. No internal state machine is involved.
- When exe_valid=0 and flush=1 together, only the counter condition is affected.

## Structure
- Shared package `arm_pkg`:
  - EXE_CMD localparams: CMD_MOV 0001, CMD_MVN 1001, CMD_ADD 0010, CMD_ADC 0011, CMD_SUB 0100, CMD_SBC 0101, CMD_AND 0110, CMD_ORR 0111, CMD_EOR 1000.
  - Condition-code localparams COND_EQ through COND_NV.
  - NZCV bit-index constants.
- One sub-module, `cond_check`: purely combinational (4-bit cond, 4-bit flags) → pass. It is reusable by the branch unit.
- Registers: 4-bit sr and a CNT_W-bit counter only.

## Test plan
- Reset and arithmetic write:
  - Stimulus: release rst_n, then exe_valid=1, s=1, cmd=0100, alu NZCV=0110.
  - Required: sr=0000 before the edge and sr=0110 after it; carry_in=1.
- Logical write preserves C and V:
  - Stimulus: sr=0011, then exe cmd=0110, s=1, alu NZCV=1000.
  - Required: sr=1011 next cycle.
- Bypass:
  - Stimulus: sr=0000, exe cmd=0100, s=1, alu_z=1, id_cond=0000 in the same cycle.
  - Required: cond_pass=1. The same cycle with exe_s=0 gives cond_pass=0.
- All 16 conditions:
  - Stimulus: sweep all 16 sr values with id_valid=1 and exe_valid=0.
  - Required: cond_pass matches the decode list. Spot check: sr=1001 makes GE pass and LT fail; sr=0100 makes LS pass and HI fail.
- Counter behaviour:
  - Stimulus: id_cond=1111 held for 3 cycles, with freeze=1 in the middle cycle.
  - Required: annul_cnt=2. Cases with CNT_W=2 and 5 fails: the counter saturates at 3. cnt_clr together with a fail: the counter reads 0.
- Async reset mid-write:
  - Stimulus: assert rst_n low between edges while sr=1111.
  - Required: sr=0000 immediately and annul_cnt=0.

Source files
------------

// File: rtl/status_cond_unit_pkg.sv
// status_cond_unit_pkg: shared ARM pipeline constants and the flag write-mask helper
package arm_pkg;
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  // arithmetic ops own all four flags, logical/move ops only N and Z
  function automatic logic [3:0] write_mask(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: write_mask = 4'b1111;
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: write_mask = 4'b1100;
      default: write_mask = 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/status_cond_unit_if.sv
// status_cond_unit_if: EXE flag-write, ID condition and counter signals of the status unit
interface status_cond_unit_if #(parameter int CNT_W = 16);
  logic exe_valid, exe_s, alu_n, alu_z, alu_c, alu_v;
  logic id_valid, freeze, flush, cnt_clr;
  logic [3:0] exe_cmd, id_cond;
  logic [3:0] sr;
  logic carry_in, cond_pass;
  logic [CNT_W-1:0] annul_cnt;
  modport master(
    output exe_valid, exe_s, exe_cmd, alu_n, alu_z, alu_c, alu_v,
    output id_valid, id_cond, freeze, flush, cnt_clr,
    input sr, carry_in, cond_pass, annul_cnt
  );
  modport slave(
    input exe_valid, exe_s, exe_cmd, alu_n, alu_z, alu_c, alu_v,
    input id_valid, id_cond, freeze, flush, cnt_clr,
    output sr, carry_in, cond_pass, annul_cnt
  );
endinterface

// File: rtl/status_cond_unit_cond_check.sv
// cond_check: combinational ARM condition-code evaluation against NZCV flags
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);
  logic w_base;
  logic w_n, w_z, w_c, w_v;
  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];
  // conditions come in pairs; odd codes are the inverse of their even partner
  always_comb begin
    case (i_cond[3:1])
      3'b000: w_base = w_z;
      3'b001: w_base = w_c;
      3'b010: w_base = w_n;
      3'b011: w_base = w_v;
      3'b100: w_base = w_c & ~w_z;
      3'b101: w_base = w_n ~^ w_v;
      3'b110: w_base = ~w_z & (w_n ~^ w_v);
      default: w_base = 1'b1;
    endcase
  end
  assign o_pass = w_base ^ i_cond[0];
endmodule

// File: rtl/status_cond_unit.sv
// status_cond_unit: NZCV status register with bypassed condition check and annul counter
module status_cond_unit
  import arm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  status_cond_unit_if.slave bus
);
  logic [3:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0] w_mask, w_alu, w_sr_next;
  logic w_dec, w_pass, w_inc;
  assign w_alu = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
  assign w_mask = (bus.exe_valid && bus.exe_s) ? write_mask(bus.exe_cmd) : 4'b0000;
  assign w_sr_next = (r_sr & ~w_mask) | (w_alu & w_mask);
  cond_check u_cond_check (
    .i_cond (bus.id_cond),
    .i_flags(w_sr_next),
    .o_pass (w_dec)
  );
  assign w_pass = w_dec & bus.id_valid;
  assign w_inc = bus.id_valid & ~w_pass & ~bus.freeze & ~bus.flush & ~(&r_cnt);
  // flags take the EXE write on the edge after the EXE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sr <= 4'b0000;
    else r_sr <= w_sr_next;
  end
  // annulled ID instructions counted as they leave ID, clear wins, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (bus.cnt_clr) r_cnt <= '0;
    else if (w_inc) r_cnt <= r_cnt + 1'b1;
  end
  assign bus.sr = r_sr;
  assign bus.carry_in = r_sr[FLAG_C];
  assign bus.cond_pass = w_pass;
  assign bus.annul_cnt = r_cnt;
endmodule
